// File: rtl/trng_vn_packer.sv
// trng_vn_packer: repetition-count health test, von Neumann debiaser
// and LSB-first byte packer with a one-byte hold buffer.
module trng_vn_packer #(
  parameter int unsigned REP_LIMIT = 16
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       en,
  input  logic       raw_bit,
  input  logic       raw_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       health_fail,
  input  logic       fail_clr,
  output logic       overrun
);

  localparam int unsigned CW = $clog2(REP_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(REP_LIMIT);

  typedef enum logic {
    IDLE,
    HALF
  } st_e;

  st_e           st_q, st_d;
  logic          a_q, a_d;
  logic [CW-1:0] rep_q, rep_d;
  logic          last_q, last_d;
  logic          hf_q, hf_d;
  logic          ovr_q, ovr_d;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          pf_q, pf_d;
  logic [7:0]    od_q, od_d;
  logic          ov_q, ov_d;

  logic          sample;
  logic          hf_set;
  logic          flush;
  logic          accept;
  logic          db_v;
  logic [7:0]    full_w;

  assign sample = en && raw_valid;
  assign accept = ov_q && out_ready;
  assign flush  = hf_q || hf_set;

  // Repetition-count test on raw bits and the sticky failure flag.
  always_comb begin
    rep_d  = rep_q;
    last_d = last_q;
    if (sample) begin
      if (raw_bit == last_q) begin
        if (rep_q != LIM) rep_d = rep_q + CW'(1);
      end else begin
        rep_d = CW'(1);
      end
      last_d = raw_bit;
    end
    hf_set = sample && (rep_d == LIM);
    if (fail_clr) rep_d = '0;
    hf_d = hf_set || (hf_q && !fail_clr);
  end

  // Pair debiaser, packer, hold buffer and output register.
  always_comb begin
    st_d   = st_q;
    a_d    = a_q;
    db_v   = 1'b0;
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    pf_d   = pf_q;
    od_d   = od_q;
    ov_d   = ov_q && !accept;
    ovr_d  = ovr_q && !fail_clr;
    full_w = sr_q;
    full_w[cnt_q] = a_q;

    if (sample) begin
      case (st_q)
        IDLE: begin
          a_d  = raw_bit;
          st_d = HALF;
        end
        HALF: begin
          st_d = IDLE;
          db_v = (a_q != raw_bit);
        end
        default: st_d = IDLE;
      endcase
    end

    if (en && pf_q && accept) begin
      od_d = sr_q;
      ov_d = 1'b1;
      pf_d = 1'b0;
    end

    if (db_v) begin
      if (pf_q) begin
        ovr_d = 1'b1;
      end else begin
        sr_d  = full_w;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          if (!ov_q || accept) begin
            od_d = full_w;
            ov_d = 1'b1;
          end else begin
            pf_d = 1'b1;
          end
        end
      end
    end

    if (!en) begin
      st_d  = IDLE;
      cnt_d = 3'd0;
      pf_d  = 1'b0;
    end

    if (flush) begin
      st_d  = IDLE;
      cnt_d = 3'd0;
      pf_d  = 1'b0;
      ov_d  = 1'b0;
      ovr_d = ovr_q && !fail_clr;
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      st_q   <= IDLE;
      a_q    <= 1'b0;
      rep_q  <= '0;
      last_q <= 1'b0;
      hf_q   <= 1'b0;
      ovr_q  <= 1'b0;
      sr_q   <= 8'h00;
      cnt_q  <= 3'd0;
      pf_q   <= 1'b0;
      od_q   <= 8'h00;
      ov_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      a_q    <= a_d;
      rep_q  <= rep_d;
      last_q <= last_d;
      hf_q   <= hf_d;
      ovr_q  <= ovr_d;
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      pf_q   <= pf_d;
      od_q   <= od_d;
      ov_q   <= ov_d;
    end
  end

  assign out_data    = od_q;
  assign out_valid   = ov_q;
  assign health_fail = hf_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_trng_vn_packer.sv
// tb_trng_vn_packer: directed and random stimulus, queue-based
// reference model and scoreboard monitor for trng_vn_packer.
module tb_trng_vn_packer;

  localparam int REP = 16;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       en = 1'b0;
  logic       raw_bit = 1'b0;
  logic       raw_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       fail_clr = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       health_fail;
  logic       overrun;

  int errs = 0;
  int checks = 0;
  int nbytes = 0;
  logic [7:0] last_byte = 8'h00;

  // reference model state
  bit         m_last = 1'b0;
  int         m_rep = 0;
  bit         m_hf = 1'b0;
  bit         m_ov = 1'b0;
  int         m_pend = -1;
  bit         bits[$];
  int         m_buf = 0;
  logic [7:0] sb_q[$];

  trng_vn_packer #(.REP_LIMIT(REP)) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .en(en),
    .raw_bit(raw_bit),
    .raw_valid(raw_valid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .health_fail(health_fail),
    .fail_clr(fail_clr),
    .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1'b0;
    m_rep  = 0;
    m_hf   = 1'b0;
    m_ov   = 1'b0;
    m_pend = -1;
    bits.delete();
    m_buf  = 0;
    sb_q.delete();
  endtask

  task automatic model_step();
    bit smp, set, acc, hf_pre, ovset, emit, eb;
    int pre;
    logic [7:0] v;
    smp    = en && raw_valid;
    set    = 1'b0;
    ovset  = 1'b0;
    emit   = 1'b0;
    eb     = 1'b0;
    hf_pre = m_hf;
    pre    = m_buf;
    acc    = (pre > 0) && out_ready;
    if (smp) begin
      if (raw_bit == m_last) begin
        if (m_rep < REP) m_rep++;
      end else begin
        m_rep = 1;
      end
      m_last = raw_bit;
      set = (m_rep == REP);
    end
    if (fail_clr) m_rep = 0;
    if (hf_pre || set) begin
      m_pend = -1;
      bits.delete();
      m_buf = 0;
      sb_q.delete();
    end else begin
      if (acc) m_buf--;
      if (smp) begin
        if (m_pend < 0) begin
          m_pend = int'(raw_bit);
        end else begin
          if (m_pend != int'(raw_bit)) begin
            emit = 1'b1;
            eb = (m_pend == 1);
          end
          m_pend = -1;
        end
      end
      if (emit) begin
        if (pre == 2) begin
          ovset = 1'b1;
        end else begin
          bits.push_back(eb);
          if (bits.size() == 8) begin
            v = 8'h00;
            for (int i = 0; i < 8; i++) v[i] = bits[i];
            sb_q.push_back(v);
            m_buf++;
            bits.delete();
          end
        end
      end
      if (!en) begin
        m_pend = -1;
        bits.delete();
        if (pre == 2) begin
          void'(sb_q.pop_back());
          m_buf--;
        end
      end
    end
    m_hf = set || (hf_pre && !fail_clr);
    m_ov = ovset || (m_ov && !fail_clr);
  endtask

  // model advances on every clock edge or asynchronous reset
  initial forever begin
    @(posedge CLK or negedge RSTn);
    if (!RSTn) model_reset();
    else model_step();
  end

  // monitor: flags every cycle, bytes on each handshake
  initial forever begin
    logic [7:0] e;
    @(negedge CLK);
    #1;
    chk("out_valid", out_valid, m_buf > 0);
    chk("health_fail", health_fail, m_hf);
    chk("overrun", overrun, m_ov);
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL out_data: unexpected byte %02h", out_data);
      end else begin
        e = sb_q.pop_front();
        chk("out_data", out_data, e);
        nbytes++;
        last_byte = out_data;
      end
    end
  end

  task automatic bit_in(input logic b);
    @(negedge CLK);
    raw_bit = b;
    raw_valid = 1'b1;
  endtask

  task automatic pair(input logic a, input logic b);
    bit_in(a);
    bit_in(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      raw_valid = 1'b0;
    end
  endtask

  task automatic pat55();
    for (int i = 0; i < 4; i++) begin
      pair(1'b1, 1'b0);
      pair(1'b0, 1'b1);
    end
  endtask

  initial begin
    int n0;
    int thr;
    logic [7:0] exp_b;
    logic a;

    // reset with random inputs
    repeat (5) begin
      @(negedge CLK);
      en = 1'($urandom);
      raw_bit = 1'($urandom);
      raw_valid = 1'($urandom);
      out_ready = 1'($urandom);
      fail_clr = 1'($urandom);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    en = 1'b1;
    raw_valid = 1'b0;
    out_ready = 1'b0;
    fail_clr = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_health", health_fail, 0);
    chk("rst_overrun", overrun, 0);

    // packing
    pat55();
    idle(1);
    #2;
    chk("pack_valid", out_valid, 1);
    chk("pack_data", out_data, 8'h55);
    @(negedge CLK);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    #2;
    chk("pack_drop", out_valid, 0);
    chk("pack_count", nbytes, 1);

    // discard equal pairs
    out_ready = 1'b1;
    n0 = nbytes;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) pair(1'b0, 1'b0);
      else pair(1'b1, 1'b1);
    end
    idle(2);
    chk("eq_only_none", nbytes, n0);
    for (int i = 0; i < 8; i++) begin
      pair(1'b1, 1'b0);
      if (i < 7) begin
        if (i % 2 == 0) pair(1'b0, 1'b0);
        else pair(1'b1, 1'b1);
      end
    end
    idle(2);
    chk("disc_count", nbytes, n0 + 1);
    chk("disc_byte", last_byte, 8'hFF);

    // backpressure
    @(negedge CLK);
    out_ready = 1'b0;
    for (int i = 0; i < 24; i++) pair(1'b1, 1'b0);
    idle(1);
    #2;
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 8'hFF);
    chk("bp_overrun", overrun, 1);
    n0 = nbytes;
    @(negedge CLK);
    out_ready = 1'b1;
    idle(3);
    #2;
    chk("bp_two", nbytes, n0 + 2);
    chk("bp_last", last_byte, 8'hFF);
    chk("bp_empty", out_valid, 0);

    // health failure with a byte and partial byte pending
    @(negedge CLK);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) pair(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pair(1'b1, 1'b0);
    for (int i = 0; i < REP - 1; i++) bit_in(1'b1);
    idle(1);
    #2;
    chk("hf_before", health_fail, 0);
    chk("hf_byte_held", out_valid, 1);
    bit_in(1'b1);
    idle(1);
    #2;
    chk("hf_set", health_fail, 1);
    chk("hf_flush", out_valid, 0);
    n0 = nbytes;
    @(negedge CLK);
    out_ready = 1'b1;
    pat55();
    idle(2);
    chk("hf_no_bytes", nbytes, n0);
    @(negedge CLK);
    fail_clr = 1'b1;
    @(negedge CLK);
    fail_clr = 1'b0;
    #2;
    chk("clr_health", health_fail, 0);
    chk("clr_overrun", overrun, 0);
    pat55();
    idle(2);
    chk("clr_count", nbytes, n0 + 1);
    chk("clr_byte", last_byte, 8'h55);

    // asynchronous reset mid-operation
    @(negedge CLK);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) pair(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) pair(1'b1, 1'b0);
    bit_in(1'b1);
    @(negedge CLK);
    raw_valid = 1'b0;
    #2;
    chk("mid_valid_pre", out_valid, 1);
    #1;
    RSTn = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 8'h00);
    @(negedge CLK);
    RSTn = 1'b1;
    out_ready = 1'b1;

    // en drop mid-pair discards pair and packer
    n0 = nbytes;
    for (int i = 0; i < 3; i++) pair(1'b1, 1'b0);
    bit_in(1'b0);
    @(negedge CLK);
    en = 1'b0;
    raw_bit = 1'b1;
    raw_valid = 1'b1;
    @(negedge CLK);
    en = 1'b1;
    raw_valid = 1'b0;
    exp_b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      a = 1'($urandom);
      exp_b[i] = a;
      pair(a, !a);
    end
    idle(2);
    chk("en_count", nbytes, n0 + 1);
    chk("en_byte", last_byte, exp_b);

    // randomized traffic
    thr = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) thr = (($urandom % 3) == 0) ? 92 : 50;
      @(negedge CLK);
      en = ($urandom % 32) != 0;
      raw_valid = ($urandom % 4) != 0;
      raw_bit = ($urandom % 100) < thr;
      out_ready = ($urandom % 3) != 0;
      fail_clr = ($urandom % 64) == 0;
    end

    // drain
    @(negedge CLK);
    en = 1'b1;
    raw_valid = 1'b0;
    fail_clr = 1'b0;
    out_ready = 1'b1;
    idle(4);
    #2;
    chk("drain_sb", sb_q.size(), 0);
    chk("drain_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/trng_vn_packer.md
# trng_vn_packer

Post-processing stage directly downstream of the ring-oscillator entropy source. It takes the raw one-bit entropy stream and runs a repetition-count health test on it. It then applies von Neumann debiasing and packs the debiased bits into bytes. Bytes are delivered over a valid/ready interface to the top-level output mux. Two byte-level buffers absorb consumer stalls; excess bits are dropped and flagged.

## Interface
Parameters:
- REP_LIMIT, 16: repetition-count cutoff; legal range 2..255; counter width is $clog2(REP_LIMIT+1).

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- en  in  1  enable; when 0, raw input is ignored and the debias/pack front end is cleared.
- raw_bit  in  1  raw entropy bit from the ring-oscillator source.
- raw_valid  in  1  raw_bit is sampled on any edge where raw_valid=1 and en=1.
- out_data  out  8  debiased byte; the first debiased bit lands in bit 0 (LSB-first).
- out_valid  out  1  out_data holds an unconsumed byte.
- out_ready  in  1  consumer accepts out_data on any edge where out_valid=1 and out_ready=1.
- health_fail  out  1  sticky repetition-test failure.
- fail_clr  in  1  synchronous clear of health_fail.
- overrun  out  1  sticky; a debiased bit was dropped because both buffers were full. Cleared only by reset or fail_clr.

## Operation
- Repetition test runs on every sampled raw bit, before debiasing, using rep_cnt and last_bit:
  - bit equal to last_bit: rep_cnt increments, saturating at REP_LIMIT.
  - bit differs: rep_cnt=1 and last_bit=bit.
  - First sampled bit after reset: rep_cnt=1.
  - When the new rep_cnt value equals REP_LIMIT, health_fail is set on that edge.
- fail_clr=1 clears health_fail, overrun and rep_cnt (to 0). If a set and fail_clr coincide on the same edge, the set wins.
- Debiaser FSM has two states:
  - IDLE: a sampled bit is stored as `a`; go to HALF.
  - HALF: a sampled bit `b` completes the pair; go to IDLE.
  - Pair result: a≠b emits debiased bit `a` (pair 1,0 gives 1; pair 0,1 gives 0). a=b emits nothing.
- Packer: an 8-bit shift register plus a 3-bit count. A debiased bit is written to position count. On the 8th bit the byte is complete.
- Complete-byte routing:
  - Output register empty, or being drained on the same edge: the byte loads straight into out_data/out_valid.
  - Otherwise the packer holds the full byte (pack_full=1).
- pack_full=1: the held byte moves to the output register on the edge where out_valid&&out_ready. Any debiased bit arriving while pack_full=1 is dropped and sets overrun.
- health_fail=1 (including the edge it sets): the FSM is forced to IDLE, and the packer, pack_full and out_valid are flushed. No bytes are produced until fail_clr. The repetition test keeps running.
- en=0: the FSM is forced to IDLE and the packer count and pack_full are cleared. The output register and handshake are unaffected. rep_cnt and last_bit hold.
- Asynchronous reset clears everything: out_data=0, out_valid=0, health_fail=0, overrun=0, rep_cnt=0, last_bit=0, FSM IDLE, packer empty.

## Timing
- A raw bit is sampled on edge N. A completed byte with the output register free gives out_valid=1 in the cycle after edge N, which is one cycle of latency.
- out_data is stable while out_valid=1 and out_ready=0. Dropping out_valid without a handshake is permitted only on health_fail or reset.
- Back-to-back bytes:
  - Packer full at acceptance: out_valid stays 1 and the next byte appears the cycle after acceptance.
  - Packer empty at acceptance: out_valid falls the cycle after acceptance.
- health_fail rises the cycle after the sampling edge of the REP_LIMIT-th identical bit. out_valid falls in the same cycle.
- Throughput: at most one raw bit per cycle, so at most one debiased bit every two cycles.

## Test plan
- Reset: hold RSTn=0 with random inputs, then release. out_valid=0, out_data=0x00, health_fail=0, overrun=0. The first pair 1,0 emits bit 1.
- Packing: en=1, raw bits 1,0 / 0,1 repeated 4 times (16 bits, one per cycle). out_data=0x55 and out_valid=1 the cycle after the 16th bit. Accept with out_ready=1; out_valid falls the next cycle.
- Discard: interleave pairs 0,0 and 1,1 between the eight 1,0 pairs. out_data=0xFF. No byte is produced from the equal pairs alone.
- Backpressure: out_ready=0, feed 24 debiased 1s. The first byte is in out_data, the second is held in the packer, and overrun=1. Raise out_ready: two 0xFF bytes on consecutive acceptances, then out_valid=0.
- Health: REP_LIMIT=16, a partial byte pending, then 16 consecutive raw 1s. health_fail=1 and out_valid=0 the cycle after the 16th bit; further 1,0 pairs produce nothing. Pulse fail_clr: health_fail=0, overrun=0, and a fresh 0x55 is packed normally.
- Mid-operation: assert RSTn=0 asynchronously with a half pair and 5 packed bits pending. Outputs clear immediately. Deassert en mid-pair: the pair and packer are discarded, and the next 8 pairs yield one correct byte.
